fft_out_drain: RTL



---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_frame_ram.sv | 27 ++
 rtl/fft_out_drain.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes and types for the FFT output drain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

  // Parallel lanes per FFT beat.
  localparam int LANES       = 16;
  // Word width: [63:32] real, [31:0] imag, never modified here.
  localparam int W           = 64;
  // Maximum beats per frame (65536 points / 16 lanes).
  localparam int FRAME_BEATS = 4096;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    DRAIN
  } drain_state_t;

  typedef logic [W-1:0] beat_t [LANES];

endpackage

// File: rtl/fft_frame_ram.sv
// fft_frame_ram: simple dual-port frame buffer, DEPTH rows of DW bits, no reset on storage.
// Latency: write lands at the edge; read data registered one edge after re/raddr.
// Backpressure: none; rdata holds its value while re is low.
// Ports: CLK; write port we/waddr/wdata; read port re/raddr/rdata.
module fft_frame_ram #(
  parameter  int DEPTH = 4096,
  parameter  int DW    = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    // Holding rdata when re is low lets the reader park a fetched row.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_out_drain.sv
// fft_out_drain: captures a burst of 16-lane FFT beats into a frame buffer, then streams it word by word.
// Latency: first O_VALID two edges after entering DRAIN; sustains 1 word/cycle with O_READY high.
// Backpressure: O_READY stalls the output word; capture side cannot stall, so late/excess beats set OVF.
// Ports: CLK/RST; DONE + Q0..Q15 capture input; O_DATA/O_VALID/O_READY/O_LAST stream; BUSY; OVF/OVF_CLR.
module fft_out_drain #(
  parameter int LANES       = fft_pkg::LANES,
  parameter int W           = fft_pkg::W,
  parameter int FRAME_BEATS = fft_pkg::FRAME_BEATS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         DONE,
  input  logic [W-1:0] Q0,
  input  logic [W-1:0] Q1,
  input  logic [W-1:0] Q2,
  input  logic [W-1:0] Q3,
  input  logic [W-1:0] Q4,
  input  logic [W-1:0] Q5,
  input  logic [W-1:0] Q6,
  input  logic [W-1:0] Q7,
  input  logic [W-1:0] Q8,
  input  logic [W-1:0] Q9,
  input  logic [W-1:0] Q10,
  input  logic [W-1:0] Q11,
  input  logic [W-1:0] Q12,
  input  logic [W-1:0] Q13,
  input  logic [W-1:0] Q14,
  input  logic [W-1:0] Q15,
  output logic [W-1:0] O_DATA,
  output logic         O_VALID,
  input  logic         O_READY,
  output logic         O_LAST,
  output logic         BUSY,
  output logic         OVF,
  input  logic         OVF_CLR
);
  import fft_pkg::*;

  localparam int RW = $clog2(FRAME_BEATS);
  localparam int CW = RW + 1;
  localparam int LW = $clog2(LANES);

  drain_state_t     state;
  logic             done_q;
  logic [CW-1:0]    count;     // rows captured in this frame
  logic [RW-1:0]    rd_row;    // next row to fetch from the buffer
  logic             rd_all;    // every captured row has been fetched
  logic             rd_vld;    // RAM read register holds an unconsumed row
  logic             rd_last;   // ...and it is the final row of the frame
  logic             row_vld;   // prefetch row register holds lanes still to send
  logic             row_last;
  logic [LW-1:0]    lane;      // next lane of the prefetch row to present
  logic [W-1:0]     row_buf [LANES];

  logic [LANES*W-1:0] wdata;
  logic [LANES*W-1:0] rdata;
  logic               we;
  logic               cap_full;
  logic               out_free;
  logic               take_row;
  logic               row_done;
  logic               load_row;
  logic               last_row;
  logic               issue_rd;
  logic               last_hs;

  // Lane l occupies bits [l*W +: W] of a buffer row.
  assign wdata = {Q15, Q14, Q13, Q12, Q11, Q10, Q9, Q8,
                  Q7,  Q6,  Q5,  Q4,  Q3,  Q2,  Q1, Q0};

  assign cap_full = (count == CW'(FRAME_BEATS));
  // In IDLE count is 0, so the write address is row 0 without a separate mux.
  assign we       = done_q && ((state == IDLE) || ((state == CAPT) && !cap_full));

  // Three-stage read pipeline: RAM read register -> prefetch row -> output word.
  // A stage may refill on the same edge it empties, which keeps the stream gap-free:
  // the next row is fetched while lane 15 of the current row is being presented.
  assign out_free = !O_VALID || O_READY;
  assign take_row = out_free && row_vld;
  assign row_done = take_row && (lane == LW'(LANES - 1));
  assign load_row = rd_vld && (!row_vld || row_done);
  assign last_row = ({1'b0, rd_row} == (count - CW'(1)));
  // The first fetch goes out on the same edge that leaves CAPT, once count is final.
  assign issue_rd = !rd_all && (!rd_vld || load_row) &&
                    ((state == DRAIN) || ((state == CAPT) && !done_q));
  assign last_hs  = O_VALID && O_READY && O_LAST;

  assign BUSY = (state != IDLE);

  fft_frame_ram #(
    .DEPTH (FRAME_BEATS),
    .DW    (LANES * W)
  ) u_ram (
    .CLK   (CLK),
    .we    (we),
    .waddr (count[RW-1:0]),
    .wdata (wdata),
    .re    (issue_rd),
    .raddr (rd_row),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      count    <= '0;
      rd_row   <= '0;
      rd_all   <= 1'b0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      row_vld  <= 1'b0;
      row_last <= 1'b0;
      lane     <= '0;
      O_DATA   <= '0;
      O_VALID  <= 1'b0;
      O_LAST   <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      done_q <= DONE;

      // Any set below overrides this clear.
      if (OVF_CLR) OVF <= 1'b0;

      case (state)
        IDLE: begin
          if (done_q) begin
            count <= CW'(1);
            state <= CAPT;
          end
        end
        CAPT: begin
          if (!done_q)        state <= DRAIN;
          else if (!cap_full) count <= count + CW'(1);
          else                OVF   <= 1'b1;
        end
        DRAIN: begin
          // Beats arriving mid-drain have nowhere to go.
          if (done_q) OVF <= 1'b1;
          if (last_hs) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue_rd) begin
        rd_row  <= rd_row + RW'(1);
        rd_vld  <= 1'b1;
        rd_last <= last_row;
        if (last_row) rd_all <= 1'b1;
      end else if (load_row) begin
        rd_vld <= 1'b0;
      end

      if (load_row) begin
        row_vld  <= 1'b1;
        row_last <= rd_last;
      end else if (row_done) begin
        row_vld <= 1'b0;
      end

      if (take_row) begin
        lane    <= lane + LW'(1);
        O_DATA  <= row_buf[lane];
        O_VALID <= 1'b1;
        O_LAST  <= row_last && (lane == LW'(LANES - 1));
      end else if (O_VALID && O_READY) begin
        O_VALID <= 1'b0;
        O_LAST  <= 1'b0;
      end

      if (last_hs) begin
        rd_row <= '0;
        rd_all <= 1'b0;
      end
    end
  end

  // Prefetch row data carries no reset; row_vld qualifies it.
  always_ff @(posedge CLK) begin
    if (load_row) begin
      for (int l = 0; l < LANES; l++) row_buf[l] <= rdata[l*W +: W];
    end
  end

endmodule
